snake_btn_debouncer: RTL

Debounces one raw asynchronous push-button and converts it into clean, single-clock control pulses for the snake game logic. One instance is placed per button (L, R, U, D, C) between the board pins and snake_core. The block synchronizes the pin, rejects bounce shorter than the debounce window, and produces four outputs:
- a debounced level;
- a single press pulse;
- a hold-repeat pulse train;
- a continuous-hold enable.

---
 rtl/snake_btn_debouncer.sv | 129 ++++++++++++
 1 files changed

// File: rtl/snake_btn_debouncer.sv
`default_nettype none
// ==========================================================================
// snake_btn_debouncer : push-button synchronizer/debouncer -> DPB/SCEN/MCEN/CCEN
// Rev 1.0
// ==========================================================================
module snake_btn_debouncer #(
   parameter int N_dc = 25
) (
   input  logic Clk,
   input  logic Reset_n,
   input  logic PB,
   output logic DPB,
   output logic SCEN,
   output logic MCEN,
   output logic CCEN
);

   localparam logic [N_dc-1:0] CNT_MAX = '1;

   typedef enum logic [2:0] {
      IDLE         = 3'd0,
      PRESS_WAIT   = 3'd1,
      PULSE        = 3'd2,
      HELD         = 3'd3,
      RELEASE_WAIT = 3'd4
   } state_t;

   state_t            state, state_nx;
   logic [N_dc-1:0]   cnt, cnt_nx;
   logic [1:0]        rpt, rpt_nx;
   logic              s1, s2;
   logic              pb_s;
   logic              dpb_nx, scen_nx, mcen_nx, ccen_nx;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= PB;
         s2 <= s1;
      end
   end

   assign pb_s = s2;

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt + 1'b1;
      rpt_nx   = rpt;
      dpb_nx   = 1'b0;
      scen_nx  = 1'b0;
      mcen_nx  = 1'b0;
      ccen_nx  = 1'b0;

      case (state)
         IDLE: begin
            if (pb_s) state_nx = PRESS_WAIT;
         end
         PRESS_WAIT: begin
            if (!pb_s)                state_nx = IDLE;
            else if (cnt == CNT_MAX)  state_nx = PULSE;
         end
         PULSE: begin
            state_nx = HELD;
         end
         HELD: begin
            if (!pb_s) state_nx = RELEASE_WAIT;
         end
         RELEASE_WAIT: begin
            if (pb_s)                 state_nx = HELD;
            else if (cnt == CNT_MAX)  state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase

      // In HELD the counter simply wraps; every other change of state restarts it.
      if (state_nx != state) cnt_nx = '0;

      // Outputs are decoded from the next state so they are registered with it.
      case (state_nx)
         PULSE: begin
            rpt_nx  = 2'd0;
            dpb_nx  = 1'b1;
            scen_nx = 1'b1;
            mcen_nx = 1'b1;
            ccen_nx = 1'b1;
         end
         HELD: begin
            dpb_nx = 1'b1;
            if (cnt_nx == CNT_MAX) begin
               mcen_nx = 1'b1;
               if (rpt != 2'd3) rpt_nx = rpt + 2'd1;
            end
            ccen_nx = (rpt_nx == 2'd3);
         end
         RELEASE_WAIT: begin
            dpb_nx = 1'b1;
         end
         default: begin
            dpb_nx = 1'b0;
         end
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state <= IDLE;
         cnt   <= '0;
         rpt   <= 2'd0;
         DPB   <= 1'b0;
         SCEN  <= 1'b0;
         MCEN  <= 1'b0;
         CCEN  <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         rpt   <= rpt_nx;
         DPB   <= dpb_nx;
         SCEN  <= scen_nx;
         MCEN  <= mcen_nx;
         CCEN  <= ccen_nx;
      end
   end

endmodule
`default_nettype wire
